// File: rtl/mul_div_unit_pkg.sv
// cpu_pkg: shared encodings and defaults for the multiply/divide unit
package cpu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_FIX  = 2'b10
    } mdu_state_e;

    function automatic logic mdu_is_div(input mdu_op_e op);
        return op inside {MDU_DIVU, MDU_DIV};
    endfunction

    function automatic logic mdu_is_signed(input mdu_op_e op);
        return op inside {MDU_MULT, MDU_DIV};
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: launch, MTHI/MTLO and result signals of the multiply/divide unit
interface mul_div_unit_if
    import cpu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mul_div_unit_step.sv
// mdu_step: one shift-add multiply or restoring divide iteration on {upper, lower} accumulator
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] nxt
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    // multiply adds the operand on the low bit then shifts right; divide shifts left and trial-subtracts
    always_comb begin
        sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? opnd : {WIDTH{1'b0}}};
        rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = rem - {1'b0, opnd};
        nxt  = !div ? {sum, acc[WIDTH-1:1]} :
               diff[WIDTH] ? {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                             {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit writing the HI/LO pair
module mul_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input logic           clk,
    input logic           rst,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    mdu_state_e         state;
    mdu_op_e            op_q;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [CW-1:0]      cnt;
    logic               neg_q;
    logic               neg_r;
    logic               dz;
    logic               done_q;
    logic               dbz_q;
    logic               sa;
    logic               sb;
    logic               div_zero;
    logic               div_q;

    // magnitudes and signs of the incoming operands for a launch
    always_comb begin
        sa       = mdu_is_signed(mdu_op_e'(bus.op)) & bus.a[WIDTH-1];
        sb       = mdu_is_signed(mdu_op_e'(bus.op)) & bus.b[WIDTH-1];
        abs_a    = sa ? -bus.a : bus.a;
        abs_b    = sb ? -bus.b : bus.b;
        div_zero = mdu_is_div(mdu_op_e'(bus.op)) & (bus.b == '0);
        div_q    = mdu_is_div(op_q);
    end

    // sign fix-up of the finished accumulator; divide by zero gives all-ones quotient and a in hi
    always_comb begin
        prod   = neg_q ? -acc : acc;
        quo    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        res_lo = dz ? '1 : div_q ? quo : prod[WIDTH-1:0];
        res_hi = dz ? acc[WIDTH-1:0] : div_q ? rem : prod[2*WIDTH-1:WIDTH];
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .div  (div_q),
        .acc  (acc),
        .opnd (opnd),
        .nxt  (acc_nxt)
    );

    // control FSM with MT writes, iteration count and registered results
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= MDU_IDLE;
            op_q   <= MDU_MULTU;
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                MDU_IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (bus.start) begin
                        op_q  <= mdu_op_e'(bus.op);
                        acc   <= {{WIDTH{1'b0}}, div_zero ? bus.a : abs_a};
                        opnd  <= abs_b;
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                        dz    <= div_zero;
                        dbz_q <= 1'b0;
                        cnt   <= CNT_MAX;
                        state <= div_zero ? MDU_FIX : MDU_CALC;
                    end
                end
                MDU_CALC: begin
                    acc   <= acc_nxt;
                    cnt   <= cnt - 1'b1;
                    state <= (cnt == '0) ? MDU_FIX : MDU_CALC;
                end
                MDU_FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    dbz_q  <= dz;
                    done_q <= 1'b1;
                    state  <= MDU_IDLE;
                end
                default: state <= MDU_IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != MDU_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against a cycle-count model
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err = 0;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference arithmetic: returns {hi, lo}
    function automatic logic [63:0] ref_calc(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                             output logic dz);
        longint      sx;
        longint      sy;
        logic [31:0] q;
        logic [31:0] r;
        logic [63:0] res;
        sx = $signed(x);
        sy = $signed(y);
        dz = o[1] && (y == 0);
        if (dz) res = {x, 32'hFFFF_FFFF};
        else if (o == 2'b00) res = {32'b0, x} * {32'b0, y};
        else if (o == 2'b01) res = sx * sy;
        else if (o == 2'b10) res = {x % y, x / y};
        else begin
            q = 32'(sx / sy);
            r = 32'(sx % sy);
            res = {r, q};
        end
        return res;
    endfunction

    // behavioural model: cycles remaining until completion plus architectural HI/LO
    int          m_left = 0;
    logic [31:0] m_hi = 0;
    logic [31:0] m_lo = 0;
    logic        m_done = 0;
    logic        m_dbz = 0;
    logic [63:0] p_res = 0;
    logic        p_dz = 0;

    always @(posedge clk) begin
        if (!rst) begin
            m_left = 0;
            m_hi = 0;
            m_lo = 0;
            m_done = 0;
            m_dbz = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    {m_hi, m_lo} = p_res;
                    m_dbz = p_dz;
                    m_done = 1;
                end
            end else begin
                if (bus.hi_we) m_hi = bus.wdata;
                if (bus.lo_we) m_lo = bus.wdata;
                if (bus.start) begin
                    p_res = ref_calc(bus.op, bus.a, bus.b, p_dz);
                    m_dbz = 0;
                    m_left = p_dz ? 1 : 33;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {63'b0, bus.busy}, {63'b0, m_left != 0});
        chk("done", {63'b0, bus.done}, {63'b0, m_done});
        chk("div_by_zero", {63'b0, bus.div_by_zero}, {63'b0, m_dbz});
        chk("hi", {32'b0, bus.hi}, {32'b0, m_hi});
        chk("lo", {32'b0, bus.lo}, {32'b0, m_lo});
    end

    // drive a start at the current negedge, then scramble operands to prove they were latched
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        bus.start = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
    endtask

    // wait for done (bounded), k0 = cycles already elapsed since the accepting cycle
    task automatic expect_op(input string nm, input int k0, input int lat,
                             input logic [31:0] eh, input logic [31:0] el);
        int k = k0;
        while (bus.done !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " latency"}, 64'(k), 64'(lat));
        chk({nm, " busy at done"}, {63'b0, bus.busy}, 64'd0);
        chk({nm, " hi"}, {32'b0, bus.hi}, {32'b0, eh});
        chk({nm, " lo"}, {32'b0, bus.lo}, {32'b0, el});
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic        dzp;
        logic [63:0] r;
        int          seen;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;

        r = ref_calc(2'b01, 32'hFFFF_FFFD, 32'd7, dzp);
        chk("model mult", r, 64'hFFFF_FFFF_FFFF_FFEB);
        r = ref_calc(2'b11, 32'hFFFF_FFF9, 32'd2, dzp);
        chk("model div", r, 64'hFFFF_FFFF_FFFF_FFFD);
        r = ref_calc(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, dzp);
        chk("model div wrap", r, 64'h0000_0000_8000_0000);
        r = ref_calc(2'b10, 32'h1234, 32'd0, dzp);
        chk("model dz", {r[63:1], dzp}, {32'h0000_1234, 31'h7FFF_FFFF, 1'b1});

        repeat (2) @(negedge clk);
        chk("reset busy", {63'b0, bus.busy}, 64'd0);
        chk("reset done", {63'b0, bus.done}, 64'd0);
        chk("reset dbz", {63'b0, bus.div_by_zero}, 64'd0);
        chk("reset hi", {32'b0, bus.hi}, 64'd0);
        chk("reset lo", {32'b0, bus.lo}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        launch(2'b00, 32'hFFFF_FFFF, 32'd2);
        expect_op("multu", 1, 34, 32'h0000_0001, 32'hFFFF_FFFE);
        launch(2'b01, 32'hFFFF_FFFD, 32'd7);
        expect_op("mult", 1, 34, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        launch(2'b11, 32'hFFFF_FFF9, 32'd2);
        expect_op("div", 1, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_op("div wrap", 1, 34, 32'h0, 32'h8000_0000);
        launch(2'b10, 32'd100, 32'd7);
        expect_op("divu b2b", 1, 34, 32'd2, 32'd14);

        launch(2'b10, 32'h1234, 32'd0);
        expect_op("divu dz", 1, 2, 32'h1234, 32'hFFFF_FFFF);
        chk("dz flag", {63'b0, bus.div_by_zero}, 64'd1);
        launch(2'b00, 32'd3, 32'd4);
        chk("dz cleared", {63'b0, bus.div_by_zero}, 64'd0);
        expect_op("after dz", 1, 34, 32'd0, 32'd12);

        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        chk("mthi", {32'b0, bus.hi}, {32'b0, 32'hDEAD_BEEF});
        chk("mtlo", {32'b0, bus.lo}, {32'b0, 32'hDEAD_BEEF});

        launch(2'b00, 32'd5, 32'd6);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.a = 32'd9;
        bus.b = 32'd3;
        bus.hi_we = 1'b1;
        bus.wdata = 32'hAA;
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        expect_op("interference", 6, 34, 32'd0, 32'd30);

        launch(2'b00, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort busy", {63'b0, bus.busy}, 64'd0);
        chk("abort hi", {32'b0, bus.hi}, 64'd0);
        chk("abort lo", {32'b0, bus.lo}, 64'd0);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("abort no done", 64'(seen), 64'd0);

        repeat (3000) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 5) == 0);
            bus.op = 2'($urandom_range(0, 3));
            bus.a = pick();
            bus.b = pick();
            if (bus.op == 2'b10 && $urandom_range(0, 3) == 0) bus.b = '0;
            if (bus.op == 2'b11 && bus.b == '0) bus.b = 32'd1;
            bus.hi_we = ($urandom_range(0, 9) == 0);
            bus.lo_we = ($urandom_range(0, 9) == 0);
            bus.wdata = $urandom;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
